// File: rtl/traffic_pkg.sv
// Shared types for the traffic light controller: FSM state encoding, default
// phase durations and the lamp vector with its per-state decode.
package traffic_pkg;

   typedef enum logic [2:0] {
      CAR_GREEN,
      CAR_YELLOW,
      ALL_RED_1,
      PED_GREEN,
      PED_BLINK,
      ALL_RED_2,
      CAR_RED_YELLOW,
      NIGHT_BLINK
   } state_t;

   localparam int unsigned DEF_T_GREEN_MIN  = 10;
   localparam int unsigned DEF_T_YELLOW     = 3;
   localparam int unsigned DEF_T_ALL_RED    = 2;
   localparam int unsigned DEF_T_PED_GREEN  = 8;
   localparam int unsigned DEF_T_PED_BLINK  = 4;
   localparam int unsigned DEF_T_RED_YELLOW = 2;
   localparam int unsigned DEF_TW           = 6;

   typedef struct packed {
      logic car_r;
      logic car_y;
      logic car_g;
      logic ped_r;
      logic ped_g;
   } lamps_t;

   localparam lamps_t LAMPS_ALL_RED = '{car_r: 1'b1, car_y: 1'b0, car_g: 1'b0,
                                        ped_r: 1'b1, ped_g: 1'b0};

   function automatic lamps_t lamp_decode(input state_t st, input logic blink);
      lamps_t l;
      l = '0;
      case (st)
         CAR_GREEN: begin
            l.car_g = 1'b1;
            l.ped_r = 1'b1;
         end
         CAR_YELLOW: begin
            l.car_y = 1'b1;
            l.ped_r = 1'b1;
         end
         PED_GREEN: begin
            l.car_r = 1'b1;
            l.ped_g = 1'b1;
         end
         PED_BLINK: begin
            l.car_r = 1'b1;
            l.ped_g = blink;
         end
         CAR_RED_YELLOW: begin
            l.car_r = 1'b1;
            l.car_y = 1'b1;
            l.ped_r = 1'b1;
         end
         // Night mode: only the flashing car amber, pedestrians see nothing.
         NIGHT_BLINK: begin
            l.car_y = blink;
         end
         default: begin
            l = LAMPS_ALL_RED;
         end
      endcase
      return l;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input, providing the synchronized
// level and a one-cycle pulse on its rising edge.
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic pulse
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = din;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q;
   assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Car/pedestrian intersection sequencer driven by the second-divider outputs,
// with pedestrian request latching, night flashing mode and a countdown.
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned T_GREEN_MIN  = DEF_T_GREEN_MIN,
   parameter int unsigned T_YELLOW     = DEF_T_YELLOW,
   parameter int unsigned T_ALL_RED    = DEF_T_ALL_RED,
   parameter int unsigned T_PED_GREEN  = DEF_T_PED_GREEN,
   parameter int unsigned T_PED_BLINK  = DEF_T_PED_BLINK,
   parameter int unsigned T_RED_YELLOW = DEF_T_RED_YELLOW,
   parameter int unsigned TW           = DEF_TW
) (
   input  logic          clk_100MHz,
   input  logic          reset,
   input  logic          clk_1Hz,
   input  logic          clk_halfsecond,
   input  logic          ped_btn,
   input  logic          night_mode,
   output logic          car_red,
   output logic          car_yellow,
   output logic          car_green,
   output logic          ped_red,
   output logic          ped_green,
   output logic          ped_wait,
   output logic [TW-1:0] countdown
);

   localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
   localparam logic [TW-1:0] TIMER_RESET = TW'(T_ALL_RED);

   function automatic logic [TW-1:0] duration(input state_t st);
      case (st)
         CAR_GREEN:      return TW'(T_GREEN_MIN);
         CAR_YELLOW:     return TW'(T_YELLOW);
         ALL_RED_1:      return TW'(T_ALL_RED);
         PED_GREEN:      return TW'(T_PED_GREEN);
         PED_BLINK:      return TW'(T_PED_BLINK);
         ALL_RED_2:      return TW'(T_ALL_RED);
         CAR_RED_YELLOW: return TW'(T_RED_YELLOW);
         default:        return '0;
      endcase
   endfunction

   logic clk_1hz_q, clk_1hz_d;
   logic blink_q, blink_d;
   logic sec_tick;

   logic btn_pulse;
   logic night_s;
   logic btn_level_unused;
   logic night_pulse_unused;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          ped_req_q, ped_req_d;
   lamps_t        lamps_q, lamps_d;
   logic          state_change;

   sync_edge u_btn_sync (
      .clk   (clk_100MHz),
      .reset (reset),
      .din   (ped_btn),
      .level (btn_level_unused),
      .pulse (btn_pulse)
   );

   sync_edge u_night_sync (
      .clk   (clk_100MHz),
      .reset (reset),
      .din   (night_mode),
      .level (night_s),
      .pulse (night_pulse_unused)
   );

   // Divider outputs already live in this clock domain, so one flop suffices.
   always_comb begin
      clk_1hz_d = clk_1Hz;
      blink_d   = clk_halfsecond;
   end

   assign sec_tick = clk_1Hz & ~clk_1hz_q;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      if (sec_tick) begin
         if (state_q == NIGHT_BLINK) begin
            if (!night_s) begin
               state_d = ALL_RED_2;
            end
         end else if (timer_q > TIMER_ONE) begin
            timer_d = timer_q - TIMER_ONE;
         end else begin
            case (state_q)
               CAR_GREEN: begin
                  // A button edge arriving with the tick still counts.
                  if (night_s) begin
                     state_d = NIGHT_BLINK;
                  end else if (ped_req_q | btn_pulse) begin
                     state_d = CAR_YELLOW;
                  end else begin
                     timer_d = '0;
                  end
               end
               CAR_YELLOW:     state_d = ALL_RED_1;
               ALL_RED_1:      state_d = PED_GREEN;
               PED_GREEN:      state_d = PED_BLINK;
               PED_BLINK:      state_d = ALL_RED_2;
               ALL_RED_2:      state_d = CAR_RED_YELLOW;
               CAR_RED_YELLOW: state_d = CAR_GREEN;
               default:        state_d = state_q;
            endcase
         end
      end

      state_change = (state_d != state_q);
      if (state_change) begin
         timer_d = duration(state_d);
      end

      ped_req_d = ped_req_q;
      if (btn_pulse && (state_q != PED_GREEN) && (state_q != NIGHT_BLINK)) begin
         ped_req_d = 1'b1;
      end
      // Clearing on entry wins, so a press on the entry cycle is dropped.
      if (state_change && ((state_d == PED_GREEN) || (state_d == NIGHT_BLINK))) begin
         ped_req_d = 1'b0;
      end

      lamps_d = lamp_decode(state_q, blink_q);
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         clk_1hz_q <= 1'b0;
         blink_q   <= 1'b0;
         state_q   <= ALL_RED_2;
         timer_q   <= TIMER_RESET;
         ped_req_q <= 1'b0;
         lamps_q   <= LAMPS_ALL_RED;
      end else begin
         clk_1hz_q <= clk_1hz_d;
         blink_q   <= blink_d;
         state_q   <= state_d;
         timer_q   <= timer_d;
         ped_req_q <= ped_req_d;
         lamps_q   <= lamps_d;
      end
   end

   assign car_red    = lamps_q.car_r;
   assign car_yellow = lamps_q.car_y;
   assign car_green  = lamps_q.car_g;
   assign ped_red    = lamps_q.ped_r;
   assign ped_green  = lamps_q.ped_g;
   assign ped_wait   = ped_req_q;
   assign countdown  = timer_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: a second-level phase model predicts
// lamps, countdown and request indicator after every one-second tick.
module tb_traffic_light_ctrl;

   localparam int NSEC      = 250;
   localparam int SEC_CYC   = 20;
   localparam int NPH       = 7;
   localparam int PH_GREEN  = 0;
   localparam int PH_YEL    = 1;
   localparam int PH_PG     = 3;
   localparam int PH_AR2    = 5;
   localparam int T_ALL_RED = 1;

   // Phase order G, Y, AR1, PG, PB, AR2, RY; lamp bits {car_r,car_y,car_g,ped_r,ped_g}.
   localparam int         DUR   [NPH] = '{3, 2, 1, 2, 2, 1, 1};
   localparam logic [4:0] LAMP  [NPH] = '{5'b00110, 5'b01010, 5'b10010, 5'b10001,
                                          5'b10000, 5'b10010, 5'b11010};
   localparam logic [4:0] BMASK [NPH] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000,
                                          5'b00001, 5'b00000, 5'b00000};

   typedef struct packed {
      logic [4:0] lamps;
      logic [4:0] bmask;
      logic [5:0] cd;
      logic       pw;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       clk_1Hz;
   logic       clk_halfsecond;
   logic       ped_btn;
   logic       night_mode;
   logic       car_red, car_yellow, car_green, ped_red, ped_green, ped_wait;
   logic [5:0] countdown;
   logic [4:0] lamps_obs;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   int   m_ph;
   int   m_left;
   bit   m_req;
   bit   m_night;

   assign lamps_obs = {car_red, car_yellow, car_green, ped_red, ped_green};

   traffic_light_ctrl #(
      .T_GREEN_MIN  (3),
      .T_YELLOW     (2),
      .T_ALL_RED    (T_ALL_RED),
      .T_PED_GREEN  (2),
      .T_PED_BLINK  (2),
      .T_RED_YELLOW (1),
      .TW           (6)
   ) dut (
      .clk_100MHz     (clk),
      .reset          (reset),
      .clk_1Hz        (clk_1Hz),
      .clk_halfsecond (clk_halfsecond),
      .ped_btn        (ped_btn),
      .night_mode     (night_mode),
      .car_red        (car_red),
      .car_yellow     (car_yellow),
      .car_green      (car_green),
      .ped_red        (ped_red),
      .ped_green      (ped_green),
      .ped_wait       (ped_wait),
      .countdown      (countdown)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
   endtask

   // ---------------- reference model ----------------
   function automatic void m_enter(input int p);
      m_ph   = p;
      m_left = DUR[p];
      if (p == PH_PG) m_req = 1'b0;
   endfunction

   function automatic void m_reset();
      m_ph    = PH_AR2;
      m_left  = T_ALL_RED;
      m_req   = 1'b0;
      m_night = 1'b0;
   endfunction

   function automatic void m_tick(input bit nite, input bit pulse);
      bit req_eff;
      req_eff = m_req | pulse;
      if (pulse && !m_night && m_ph != PH_PG) m_req = 1'b1;
      if (m_night) begin
         if (!nite) begin
            m_night = 1'b0;
            m_enter(PH_AR2);
         end
      end else if (m_left > 1) begin
         m_left--;
      end else if (m_ph == PH_GREEN) begin
         if (nite) begin
            m_night = 1'b1;
            m_left  = 0;
            m_req   = 1'b0;
         end else if (req_eff) begin
            m_enter(PH_YEL);
         end else begin
            m_left = 0;
         end
      end else begin
         m_enter((m_ph + 1) % NPH);
      end
   endfunction

   function automatic void m_press();
      if (!m_night && m_ph != PH_PG) m_req = 1'b1;
   endfunction

   function automatic exp_t m_expect();
      exp_t e;
      if (m_night) begin
         e.lamps = 5'b00000;
         e.bmask = 5'b01000;
         e.cd    = 6'd0;
      end else begin
         e.lamps = LAMP[m_ph];
         e.bmask = BMASK[m_ph];
         e.cd    = 6'(m_left);
      end
      e.pw = m_req;
      return e;
   endfunction

   // ---------------- stimulus ----------------
   initial begin : stim
      int  bmode;
      bit  nite_next;
      bit  do_rst;
      bit  pend;
      int  r;
      reset          = 1'b1;
      clk_1Hz        = 1'b0;
      clk_halfsecond = 1'b0;
      ped_btn        = 1'b0;
      night_mode     = 1'b0;
      nite_next      = 1'b0;
      pend           = 1'b0;
      m_reset();
      for (int i = 0; i < 3; i++) q.push_back(m_expect());
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      for (int s = 0; s < NSEC; s++) begin
         bmode  = 0;
         do_rst = 1'b0;
         if (s < 45) begin
            case (s)
               2, 7, 9, 25: bmode = 1;
               36:          bmode = 2;
               19, 40:      nite_next = 1'b1;
               31:          nite_next = 1'b0;
               38:          do_rst = 1'b1;
               44: begin
                  do_rst    = 1'b1;
                  nite_next = 1'b0;
               end
               default: ;
            endcase
         end else begin
            r     = int'($urandom_range(0, 9));
            bmode = (r < 2) ? 1 : ((r == 2) ? 2 : 0);
            if ($urandom_range(0, 11) == 0) nite_next = !nite_next;
            do_rst = ($urandom_range(0, 49) == 0);
            if (do_rst && bmode == 1) bmode = 0;
         end

         for (int c = 0; c < SEC_CYC; c++) begin
            @(negedge clk);
            clk_1Hz        = (c < 10);
            clk_halfsecond = (((c / 5) % 2) == 0);
            ped_btn        = (bmode == 1 && (c == 14 || c == 15)) || (bmode == 2 && c >= 18);
            if (c == 0) begin
               m_tick(night_mode, pend);
               pend = 1'b0;
               q.push_back(m_expect());
            end
            if (c == 14) begin
               night_mode = nite_next;
               if (do_rst) begin
                  reset = 1'b1;
                  m_reset();
                  q.push_back(m_expect());
               end
            end
            if (c == 15) reset = 1'b0;
            if (c == 16 && bmode == 1) m_press();
            if (c == 19 && bmode == 2) pend = 1'b1;
         end
      end

      repeat (30) @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // ---------------- monitor ----------------
   task automatic compare(input exp_t e, input bit b, input string tag);
      logic [4:0] el;
      el = (e.lamps & ~e.bmask) | (b ? e.bmask : 5'b00000);
      chk({tag, "_lamps"}, int'(lamps_obs), int'(el));
      chk({tag, "_countdown"}, int'(countdown), int'(e.cd));
      chk({tag, "_ped_wait"}, int'(ped_wait), int'(e.pw));
   endtask

   initial begin : monitor
      exp_t cur;
      bit   have;
      bit   prev1;
      bit   rst_seen;
      int   since;
      have  = 1'b0;
      prev1 = 1'b0;
      since = 1000;
      cur   = '0;
      forever begin
         @(posedge clk);
         rst_seen = reset;
         if (reset) begin
            prev1 = 1'b0;
         end else begin
            if (clk_1Hz && !prev1) since = 0;
            else if (since < 1000) since++;
            prev1 = clk_1Hz;
         end
         @(negedge clk);
         chk("safety_ped_vs_car", int'(ped_green & (car_green | car_yellow)), 0);
         if (rst_seen || since == 7) begin
            if (q.size() == 0) begin
               chk("scoreboard_underflow", 0, 1);
               have = 1'b0;
            end else begin
               cur  = q.pop_front();
               have = !rst_seen;
               compare(cur, 1'b0, rst_seen ? "reset" : "tick_blink0");
            end
         end else if (since == 12 && have) begin
            compare(cur, 1'b1, "tick_blink1");
         end
      end
   end

endmodule
